// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } muldiv_state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    // REM/REMU return the remainder register instead of the quotient
    function automatic logic op_is_rem(input muldiv_op_t op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_signed_a(input muldiv_op_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic op_signed_b(input muldiv_op_t op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer. All add/subtract/negate work is issued to
// the shared external ALU one operation per cycle; shifts, compares and
// result muxing stay local. Operands are made positive first, iterated
// unsigned (shift-add multiply, restoring divide) and the result is
// negated in a final ALU pass when the signs require it.
//
// state | meaning
// IDLE  | ready for a request, ALU driven with 0+0
// NEG_A | ALU computes 0-a, magnitude of rs1 stored
// NEG_B | ALU computes 0-b, magnitude of rs2 stored
// ITER  | DATA_WIDTH shift-add / restoring-divide steps
// FIX   | single ALU op negating the selected result
// DONE  | resp_valid held until resp_ready
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_input0,
    output logic [DATA_WIDTH-1:0] alu_input1,
    output logic [3:0]            alu_aluop,
    input  logic [DATA_WIDTH-1:0] alu_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    muldiv_state_t state_q;
    muldiv_op_t    op_q;
    logic [W-1:0]  hi_q, hi_d;     // product high word / partial remainder
    logic [W-1:0]  lo_q, lo_d;     // multiplier->product low word / dividend->quotient
    logic [W-1:0]  b_q,  b_d;      // multiplicand / divisor
    logic          sign_a_q, sign_b_q;
    logic [CW-1:0] cnt_q;
    logic          resp_valid_q;
    logic [W-1:0]  resp_data_q;

    muldiv_op_t    req_op_t;
    logic          req_sign_a, req_sign_b;
    logic          div_by_zero, div_overflow, special;
    logic [W-1:0]  special_res;

    logic [W-1:0]  trial;
    logic          ge, carry, lo_zero;
    logic          need_fix;
    logic [W-1:0]  result;

    assign req_op_t   = muldiv_op_t'(req_op);
    assign req_sign_a = op_signed_a(req_op_t) & req_a[W-1];
    assign req_sign_b = op_signed_b(req_op_t) & req_b[W-1];

    // Divide corner cases are answered straight from IDLE without the ALU
    always_comb begin
        div_by_zero  = op_is_div(req_op_t) && (req_b == '0);
        div_overflow = ((req_op_t == DIV) || (req_op_t == REM)) &&
                       (req_a == {1'b1, {(W-1){1'b0}}}) && (req_b == '1);
        special      = div_by_zero || div_overflow;
        special_res  = '0;
        if (div_by_zero) begin
            special_res = op_is_rem(req_op_t) ? req_a : '1;
        end else if (div_overflow) begin
            special_res = op_is_rem(req_op_t) ? '0 : req_a;
        end
    end

    assign trial   = {hi_q[W-2:0], lo_q[W-1]};
    assign ge      = hi_q[W-1] | (trial >= b_q);
    assign carry   = (alu_out < hi_q);
    assign lo_zero = (lo_q == '0);

    // Remainder follows the dividend sign; everything else follows sign_a^sign_b
    assign need_fix = op_is_rem(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q);

    // ALU operand and opcode selection for the current state
    always_comb begin
        alu_input0 = '0;
        alu_input1 = '0;
        alu_aluop  = ALU_ADD;
        case (state_q)
            NEG_A: begin
                alu_input1 = lo_q;
                alu_aluop  = ALU_SUB;
            end
            NEG_B: begin
                alu_input1 = b_q;
                alu_aluop  = ALU_SUB;
            end
            ITER: begin
                if (op_is_div(op_q)) begin
                    alu_input0 = trial;
                    alu_input1 = b_q;
                    alu_aluop  = ALU_SUB;
                end else begin
                    alu_input0 = hi_q;
                    alu_input1 = b_q;
                    alu_aluop  = ALU_ADD;
                end
            end
            FIX: begin
                if (op_is_rem(op_q)) begin
                    alu_input1 = hi_q;
                    alu_aluop  = ALU_SUB;
                end else if (op_is_div(op_q) || (op_q == MUL)) begin
                    alu_input1 = lo_q;
                    alu_aluop  = ALU_SUB;
                end else begin
                    // high word of a 2's-complement 64-bit negate: ~hi + borrow-out of -lo
                    alu_input0 = ~hi_q;
                    alu_input1 = {{(W-1){1'b0}}, lo_zero};
                    alu_aluop  = ALU_ADD;
                end
            end
            default: begin
                alu_input0 = '0;
                alu_input1 = '0;
                alu_aluop  = ALU_ADD;
            end
        endcase
    end

    // Next values of the datapath registers given the ALU result
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        case (state_q)
            NEG_A: lo_d = alu_out;
            NEG_B: b_d  = alu_out;
            ITER: begin
                if (op_is_div(op_q)) begin
                    hi_d = ge ? alu_out : trial;
                    lo_d = {lo_q[W-2:0], ge};
                end else if (lo_q[0]) begin
                    hi_d = {carry, alu_out[W-1:1]};
                    lo_d = {alu_out[0], lo_q[W-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[W-1:1]};
                    lo_d = {hi_q[0], lo_q[W-1:1]};
                end
            end
            FIX: begin
                if (op_is_rem(op_q)) begin
                    hi_d = alu_out;
                end else if (op_is_div(op_q) || (op_q == MUL)) begin
                    lo_d = alu_out;
                end else begin
                    hi_d = alu_out;
                end
            end
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
                b_d  = b_q;
            end
        endcase
    end

    // Result word picked from the values about to be registered
    always_comb begin
        if (op_is_rem(op_q)) begin
            result = hi_d;
        end else if (op_is_div(op_q) || (op_q == MUL)) begin
            result = lo_d;
        end else begin
            result = hi_d;
        end
    end

    // Sequencer FSM with registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= MUL;
            hi_q         <= '0;
            lo_q         <= '0;
            b_q          <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else if (flush) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op_t;
                        hi_q     <= '0;
                        lo_q     <= req_a;
                        b_q      <= req_b;
                        sign_a_q <= req_sign_a;
                        sign_b_q <= req_sign_b;
                        cnt_q    <= '0;
                        if (special) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= special_res;
                        end else if (req_sign_a) begin
                            state_q <= NEG_A;
                        end else if (req_sign_b) begin
                            state_q <= NEG_B;
                        end else begin
                            state_q <= ITER;
                        end
                    end
                end
                NEG_A: begin
                    lo_q    <= lo_d;
                    state_q <= sign_b_q ? NEG_B : ITER;
                end
                NEG_B: begin
                    b_q     <= b_d;
                    state_q <= ITER;
                end
                ITER: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        if (need_fix) begin
                            state_q <= FIX;
                        end else begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= result;
                        end
                    end
                end
                FIX: begin
                    hi_q         <= hi_d;
                    lo_q         <= lo_d;
                    state_q      <= DONE;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= result;
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with a behavioural ALU and an
// arithmetic reference model of the RV32M results and cycle counts.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] alu_input0, alu_input1, alu_out;
    logic [3:0]  alu_aluop;

    int checks = 0;
    int passes = 0;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_input0 (alu_input0),
        .alu_input1 (alu_input1),
        .alu_aluop  (alu_aluop),
        .alu_out    (alu_out)
    );

    // Shared ALU stand-in: only ADD and SUB are exercised
    assign alu_out = (alu_aluop == 4'd1) ? (alu_input0 - alu_input1) : (alu_input0 + alu_input1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M result from plain integer arithmetic
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pu;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            OP_MUL:    begin p = sa * sb; pu = p; return pu[31:0];  end
            OP_MULH:   begin p = sa * sb; pu = p; return pu[63:32]; end
            OP_MULHSU: begin p = sa * ub; pu = p; return pu[63:32]; end
            OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from accept edge to first resp_valid cycle (accept cycle counted as 1)
    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sa, sb, neg;
        if (op[2] && (b == 0)) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        sa  = (op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) && a[31];
        sb  = (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM) && b[31];
        neg = (op == OP_REM) ? sa : (op == OP_REMU) ? 1'b0 : (sa ^ sb);
        return 1 + int'(sa) + int'(sb) + 32 + int'(neg);
    endfunction

    // Issue a request from IDLE, wait for resp_valid, leave it pending
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] data);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        data = resp_data;
        if (!resp_valid) check("timeout_resp_valid", {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic accept_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
        int          lat;
        logic [31:0] data;
        issue(op, a, b, lat, data);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_lat"}, lat, exp_lat);
        accept_resp();
    endtask

    initial begin
        int          lat;
        logic [31:0] data, held, ra, rb;
        logic [2:0]  rop;
        bit          saw_valid;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0;
        flush = 1'b0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data",  resp_data, 32'd0);
        check("rst_busy",       {31'b0, busy}, 32'd0);
        check("rst_req_ready",  {31'b0, req_ready}, 32'd1);
        check("rst_alu_in0",    alu_input0, 32'd0);
        check("rst_alu_op",     {28'b0, alu_aluop}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed values with literal expectations
        run_and_check("mulhu_ff",   OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_and_check("mul_m3x7",   OP_MUL,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 35);
        run_and_check("mulh_m3x7",  OP_MULH,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 35);
        run_and_check("div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35);
        run_and_check("rem_m7_2",   OP_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35);
        run_and_check("divu_100_7", OP_DIVU,  32'd100,       32'd7,         32'd14,        33);
        run_and_check("remu_100_7", OP_REMU,  32'd100,       32'd7,         32'd2,         33);
        run_and_check("divu_5_0",   OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_and_check("rem_7_0",    OP_REM,   32'd7,         32'd0,         32'd7,         1);
        run_and_check("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_and_check("rem_ovf",    OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_and_check("mulhsu_neg", OP_MULHSU,32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);

        // randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_and_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb,
                          model_result(rop, ra, rb), model_latency(rop, ra, rb));
        end

        // response backpressure: result held, no new request taken
        issue(OP_DIVU, 32'd1000, 32'd33, lat, data);
        check("bp_data", data, model_result(OP_DIVU, 32'd1000, 32'd33));
        held = resp_data;
        req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd3; req_b = 32'd3;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_valid%0d", c), {31'b0, resp_valid}, 32'd1);
            check($sformatf("bp_hold%0d", c),  resp_data, held);
            check($sformatf("bp_ready%0d", c), {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        accept_resp();
        check("bp_released_valid", {31'b0, resp_valid}, 32'd0);
        check("bp_released_ready", {31'b0, req_ready}, 32'd1);
        run_and_check("after_bp", OP_MUL, 32'd3, 32'd3, 32'd9, 33);

        // flush during ITER with counter at 10 (cycle 11 after accept)
        req_op = OP_MULHU; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy",  {31'b0, busy}, 32'd0);
        check("flush_ready", {31'b0, req_ready}, 32'd1);
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_no_resp", {31'b0, saw_valid}, 32'd0);

        // flush beats req_valid in IDLE
        req_op = OP_DIVU; req_a = 32'd9; req_b = 32'd0; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy",  {31'b0, busy}, 32'd0);
        check("flush_idle_valid", {31'b0, resp_valid}, 32'd0);

        // asynchronous reset in the middle of ITER
        req_op = OP_REMU; req_a = 32'hDEAD_BEEF; req_b = 32'd12345; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'b0, busy}, 32'd0);
        check("arst_valid", {31'b0, resp_valid}, 32'd0);
        check("arst_data",  resp_data, 32'd0);
        check("arst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_and_check("after_rst", OP_REMU, 32'hDEAD_BEEF, 32'd12345,
                      model_result(OP_REMU, 32'hDEAD_BEEF, 32'd12345), 33);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
